// File: rtl/alu_mdu.sv
// ---------------------------------------------------------------------------
// alu_mdu : EX-stage datapath ALU with an iterative multiply/divide unit.
//
// The combinational ALU has zero latency and drives the EX/MEM register.
// The MDU owns the architectural HI/LO registers. It runs shift-add
// multiplies and restoring divides, one bit per cycle. The hazard unit
// stalls the pipeline while `busy` is high.
//
// Build option:
//   ALU_MDU_DIV_EN  defined   -> divider datapath and div/divu compiled in
//                   undefined -> div/divu are silent no-ops
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (aborts any MDU operation)
//   x, y      in   operands (rs, rt/imm)
//   aluop     in   combinational operation select
//   md_op     in   MDU op: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
//   md_start  in   MDU request strobe, sampled only while not busy
//   result    out  combinational result
//   zero      out  result == 0
//   overflow  out  signed overflow of add/sub
//   hi, lo    out  HI/LO registers
//   busy      out  MDU iterating
//   done      out  one-cycle pulse after HI/LO are written by mult/div
// ---------------------------------------------------------------------------
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       aluop,
    input  logic [2:0]       md_op,
    input  logic             md_start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int LOG = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // WIDTH is a power of two, so the last iteration index is all ones.
    localparam logic [LOG-1:0] LAST = {LOG{1'b1}};

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    logic [LOG-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign shamt = x[LOG-1:0];
    assign sum   = x + y;
    assign diff  = x - y;

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (aluop)
            4'd0:  result = y << shamt;
            4'd1:  result = y >> shamt;
            4'd8:  result = $signed(y) >>> shamt;
            4'd2: begin
                result   = sum;
                overflow = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            4'd3: begin
                result   = diff;
                overflow = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
            end
            4'd4:  result = x & y;
            4'd5:  result = x | y;
            4'd6:  result = x ^ y;
            4'd7:  result = ~(x | y);
            4'd10: result = hi;
            4'd11: result = lo;
            4'd12: result = {{(WIDTH-1){1'b0}}, $signed(x) < $signed(y)};
            4'd13: result = {{(WIDTH-1){1'b0}}, x < y};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

    // ------------------------------------------------------------------
    // MDU
    // ------------------------------------------------------------------
    logic [1:0]         state;
    logic [LOG-1:0]     cnt;
    logic [2*WIDTH-1:0] p;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;   // multiplicand or divisor magnitude
    logic               neg_a;  // product / quotient needs negation

    logic               accept;
    logic               is_signed_op;
    logic               sx;
    logic               sy;
    logic [WIDTH-1:0]   mag_x;
    logic [WIDTH-1:0]   mag_y;
    logic               start_mul;
    logic               start_div;
    logic [WIDTH:0]     mul_upper;
    logic [2*WIDTH-1:0] p_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    assign busy         = (state != S_IDLE);
    assign accept       = md_start && !busy;
    assign is_signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign sx           = is_signed_op && x[WIDTH-1];
    assign sy           = is_signed_op && y[WIDTH-1];
    assign mag_x        = sx ? -x : x;
    assign mag_y        = sy ? -y : y;
    assign start_mul    = accept && ((md_op == MD_MULT) || (md_op == MD_MULTU));

    // One shift-add step: add the multiplicand when the multiplier LSB is set,
    // then shift the whole product register right, keeping the carry.
    assign mul_upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : '0);
    assign prod_fix  = neg_a ? -p : p;

`ifdef ALU_MDU_DIV_EN
    logic               is_div;
    logic               neg_b;  // remainder takes the dividend sign
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign start_div = accept && ((md_op == MD_DIV) || (md_op == MD_DIVU));

    // Restoring step: shift the next dividend bit into the remainder and keep
    // the subtraction only when it does not go negative.
    assign div_trial = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, opnd};
    assign p_step    = !is_div ? {mul_upper, p[WIDTH-1:1]} :
                       div_trial[WIDTH] ? {p[2*WIDTH-2:0], 1'b0} :
                                          {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};

    // Divide by zero yields an all-ones quotient. The remainder path then
    // naturally reproduces x, sign included, so only lo is overridden.
    // MIN / -1 needs no special case: |MIN| negated wraps back to MIN.
    assign quo    = p[WIDTH-1:0];
    assign rem    = p[2*WIDTH-1:WIDTH];
    assign fin_lo = !is_div ? prod_fix[WIDTH-1:0] :
                    (opnd == '0) ? '1 : (neg_a ? -quo : quo);
    assign fin_hi = !is_div ? prod_fix[2*WIDTH-1:WIDTH] : (neg_b ? -rem : rem);
`else
    assign start_div = 1'b0;
    assign p_step    = {mul_upper, p[WIDTH-1:1]};
    assign fin_lo    = prod_fix[WIDTH-1:0];
    assign fin_hi    = prod_fix[2*WIDTH-1:WIDTH];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            p     <= '0;
            opnd  <= '0;
            neg_a <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            is_div <= 1'b0;
            neg_b  <= 1'b0;
`endif
        end else begin
            done <= (state == S_FIN);
            case (state)
                S_IDLE: begin
                    if (start_mul || start_div) begin
                        state <= S_RUN;
                        cnt   <= '0;
                        opnd  <= start_div ? mag_y : mag_x;
                        p     <= {{WIDTH{1'b0}}, (start_div ? mag_x : mag_y)};
                        neg_a <= sx ^ sy;
`ifdef ALU_MDU_DIV_EN
                        is_div <= start_div;
                        neg_b  <= sx;
`endif
                    end else if (accept && md_op == MD_MTHI) begin
                        hi <= x;
                    end else if (accept && md_op == MD_MTLO) begin
                        lo <= x;
                    end
                end
                S_RUN: begin
                    p   <= p_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    hi    <= fin_hi;
                    lo    <= fin_lo;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// ---------------------------------------------------------------------------
// tb_alu_mdu : self-checking bench for alu_mdu (WIDTH = 32).
// MDU expectations come from a 64-bit reference model and are queued when a
// request is driven, then popped when the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_alu_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [3:0]   aluop;
    logic [2:0]   md_op;
    logic         md_start;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;
    exp_t sbq[$];

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
    } comb_t;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .aluop(aluop), .md_op(md_op),
        .md_start(md_start), .result(result), .zero(zero), .overflow(overflow),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] prod;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        e.hi = '0;
        e.lo = '0;
        case (op)
            3'd0: begin
                prod = 64'(longint'($signed(a)) * longint'($signed(b)));
                e.hi = prod[63:32];
                e.lo = prod[31:0];
            end
            3'd1: begin
                prod = {32'b0, a} * {32'b0, b};
                e.hi = prod[63:32];
                e.lo = prod[31:0];
            end
            3'd2: begin
                if (b == '0) begin
                    e.lo = '1;
                    e.hi = a;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            default: begin
                if (b == '0) begin
                    e.lo = '1;
                    e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Drive one accepted request; leaves the bench just after the accepting edge.
    task automatic start_md(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        x        = a;
        y        = b;
        md_op    = op;
        md_start = 1'b1;
        if (op <= 3'd1) sbq.push_back(model_md(op, a, b));
`ifdef ALU_MDU_DIV_EN
        if (op == 3'd2 || op == 3'd3) sbq.push_back(model_md(op, a, b));
`endif
        step();
        md_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit   seen = 0;
        exp_t e;
        for (int i = 0; i < W + 4 && !seen; i++) begin
            step();
            if (done) begin
                seen = 1;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL %s: done pulsed with no request pending", name);
                end else begin
                    e = sbq.pop_front();
                    if (hi !== e.hi || lo !== e.lo) begin
                        errors++;
                        $display("FAIL %s: hi/lo got %h/%h expected %h/%h", name, hi, lo, e.hi, e.lo);
                    end
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for done", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b expected all 0", hi, lo, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_comb();
        comb_t tbl[15];
        tbl[0]  = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
        tbl[1]  = '{4'd3,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
        tbl[2]  = '{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
        tbl[3]  = '{4'd13, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        tbl[4]  = '{4'd8,  32'h00000004, 32'h80000000, 32'hF8000000, 1'b0};
        tbl[5]  = '{4'd15, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0};
        tbl[6]  = '{4'd0,  32'h00000004, 32'h00000001, 32'h00000010, 1'b0};
        tbl[7]  = '{4'd1,  32'h00000024, 32'h80000000, 32'h08000000, 1'b0};
        tbl[8]  = '{4'd4,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        tbl[9]  = '{4'd5,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0};
        tbl[10] = '{4'd6,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0};
        tbl[11] = '{4'd7,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        tbl[12] = '{4'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
        tbl[13] = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        tbl[14] = '{4'd9,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0};
        for (int i = 0; i < 15; i++) begin
            aluop = tbl[i].op;
            x     = tbl[i].a;
            y     = tbl[i].b;
            #1;
            checks++;
            if (result !== tbl[i].res || overflow !== tbl[i].ovf || zero !== (tbl[i].res == '0)) begin
                errors++;
                $display("FAIL comb[%0d] op=%0d: result=%h ovf=%b zero=%b expected %h %b %b",
                         i, tbl[i].op, result, overflow, zero, tbl[i].res, tbl[i].ovf, tbl[i].res == '0);
            end
        end
        aluop = 4'd15;
    endtask

    task automatic test_mthi_mtlo();
        start_md(3'd4, 32'd5, 32'd0);
        aluop = 4'd10;
        #1;
        checks++;
        if (result !== 32'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: mfhi=%h busy=%b expected 00000005 0", result, busy);
        end
        start_md(3'd5, 32'd9, 32'd0);
        aluop = 4'd11;
        #1;
        checks++;
        if (result !== 32'd9 || hi !== 32'd5) begin
            errors++;
            $display("FAIL mtlo: mflo=%h hi=%h expected 00000009 00000005", result, hi);
        end
    endtask

    task automatic test_mult();
        exp_t e;
        start_md(3'd4, 32'h11, 32'd0);
        start_md(3'd0, 32'hFFFFFFFD, 32'd7);
        aluop = 4'd10;
        #1;
        checks++;
        if (busy !== 1'b1 || result !== 32'h11) begin
            errors++;
            $display("FAIL mult_start: busy=%b mfhi=%h expected 1 00000011", busy, result);
        end
        for (int k = 1; k <= W; k++) begin
            step();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL mult_busy edge %0d: busy=%b done=%b expected 1 0", k, busy, done);
            end
        end
        step();
        e = sbq.pop_front();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL mult_fin: busy=%b done=%b hi=%h lo=%h expected 0 1 %h %h", busy, done, hi, lo, e.hi, e.lo);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL mult_done_pulse: done=%b expected 0", done);
        end
        for (int i = 0; i < 4; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 3'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            start_md(op, a, b);
            wait_done("mult_rand");
        end
    endtask

`ifdef ALU_MDU_DIV_EN
    task automatic test_div();
        start_md(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg7_2");
        start_md(3'd3, 32'd7, 32'd0);
        wait_done("divu_by_zero");
        start_md(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_min_neg1");
        start_md(3'd2, 32'hFFFFFFF9, 32'd0);
        wait_done("div_signed_by_zero");
        for (int i = 0; i < 4; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 3'($urandom_range(2, 3));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 28);
            start_md(op, a, b);
            wait_done("div_rand");
        end
    endtask
`else
    task automatic test_nodiv();
        bit saw = 0;
        start_md(3'd4, 32'h1234, 32'd0);
        start_md(3'd5, 32'h5678, 32'd0);
        start_md(3'd2, 32'd10, 32'd3);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL nodiv_busy: busy=%b expected 0", busy);
        end
        for (int i = 0; i < W + 3; i++) begin
            step();
            if (busy || done) saw = 1;
        end
        checks++;
        if (saw || hi !== 32'h1234 || lo !== 32'h5678) begin
            errors++;
            $display("FAIL nodiv_hilo: activity=%b hi=%h lo=%h expected 0 00001234 00005678", saw, hi, lo);
        end
    endtask
`endif

    task automatic test_busy_ignore();
        start_md(3'd0, 32'd5, 32'd6);
        step();
        step();
        md_start = 1'b1;
        md_op    = 3'd4;
        x        = 32'd123;
        step();
        step();
        md_op = 3'd1;
        x     = 32'd9;
        y     = 32'd9;
        step();
        md_start = 1'b0;
        wait_done("busy_ignore");
        step();
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd30) begin
            errors++;
            $display("FAIL busy_ignore_after: busy=%b hi=%h lo=%h expected 0 00000000 0000001e", busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        start_md(3'd1, 32'd100, 32'd200);
        wait_done("b2b_first");
        start_md(3'd0, 32'hFFFFFFFE, 32'd3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b expected 1", busy);
        end
        wait_done("b2b_second");
    endtask

    task automatic test_rst_abort();
        bit saw = 0;
        start_md(3'd4, 32'hAAAA, 32'd0);
        start_md(3'd5, 32'h5555, 32'd0);
        start_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        sbq.delete();
        repeat (10) step();
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: busy=%b hi=%h lo=%h done=%b expected all 0", busy, hi, lo, done);
        end
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (done) saw = 1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL rst_no_done: done seen=%b expected 0", saw);
        end
    endtask

    initial begin
        rst      = 1'b1;
        x        = '0;
        y        = '0;
        aluop    = 4'd15;
        md_op    = 3'd0;
        md_start = 1'b0;
        test_reset();
        test_comb();
        test_mthi_mtlo();
        test_mult();
`ifdef ALU_MDU_DIV_EN
        test_div();
`else
        test_nodiv();
`endif
        test_busy_ignore();
        test_back_to_back();
        test_rst_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
